// File: rtl/mmio_arbiter.sv
// mmio_arbiter: two-master arbiter and sequencer for the MMIO slave port.
// Grants one master at a time, issues one single-cycle MMIO access per grant and
// returns a one-cycle ack with read data / error to the owning master.
// Build option: define MMIO_ARB_FIXED_PRIO_EN for fixed priority (master 0 always
// wins contention); otherwise arbitration is round-robin.
`timescale 1ns/1ps
module mmio_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m0_wdata,
    input  logic        m0_bsel,
    input  logic        m0_ben,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    input  logic        m1_bsel,
    input  logic        m1_ben,
    output logic        m0_ack,
    output logic [15:0] m0_rdata,
    output logic        m0_err,
    output logic        m1_ack,
    output logic [15:0] m1_rdata,
    output logic        m1_err,
    output logic        mmio_en,
    output logic        mmio_we,
    output logic [15:0] mmio_addr,
    output logic [15:0] mmio_wdata,
    output logic        mmio_bsel,
    output logic        mmio_ben,
    input  logic [15:0] mmio_rdata,
    input  logic        mmio_serviced
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

    state_t      state, state_nxt;
    logic        grant;       // latch a new request this cycle
    logic        grant_m;     // which master is latched
    logic        idle_pick;   // winner of a fresh arbitration in IDLE
    // Owner of the transaction in flight. It is only ever rewritten on a grant,
    // so it doubles as the round-robin history; resetting it to 1 lets master 0
    // win the first contention.
    logic        owner;
    logic        bus_we;
    logic [15:0] rdata0_q, rdata1_q;
    logic        sel_we, sel_bsel, sel_ben;
    logic [15:0] sel_addr, sel_wdata;
    logic        resp;

    // Winner selection when arbitrating from IDLE
    always_comb begin
`ifdef MMIO_ARB_FIXED_PRIO_EN
        idle_pick = ~m0_req;
`else
        idle_pick = (m0_req && m1_req) ? ~owner : m1_req;
`endif
    end

    // Next-state and grant decision; the owner's req is stale during RESP
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_m   = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant     = 1'b1;
                    grant_m   = idle_pick;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = RESP;
            RESP: begin
                state_nxt = IDLE;
`ifdef MMIO_ARB_FIXED_PRIO_EN
                // Only master 0 may take over directly; master 1 has to win in IDLE.
                if (owner && m0_req) begin
                    grant     = 1'b1;
                    grant_m   = 1'b0;
                    state_nxt = ISSUE;
                end
`else
                if (owner ? m0_req : m1_req) begin
                    grant     = 1'b1;
                    grant_m   = ~owner;
                    state_nxt = ISSUE;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sel_we    = grant_m ? m1_we    : m0_we;
    assign sel_addr  = grant_m ? m1_addr  : m0_addr;
    assign sel_wdata = grant_m ? m1_wdata : m0_wdata;
    assign sel_bsel  = grant_m ? m1_bsel  : m0_bsel;
    assign sel_ben   = grant_m ? m1_ben   : m0_ben;

    // State register, owner and latched request fields driven onto the bus
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b1;
            bus_we     <= 1'b0;
            mmio_addr  <= 16'h0000;
            mmio_wdata <= 16'h0000;
            mmio_bsel  <= 1'b0;
            mmio_ben   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner      <= grant_m;
                bus_we     <= sel_we;
                mmio_addr  <= sel_addr;
                mmio_wdata <= sel_wdata;
                mmio_bsel  <= sel_bsel;
                mmio_ben   <= sel_ben;
            end
        end
    end

    // Per-master read data hold, loaded when that master's read completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata0_q <= 16'h0000;
            rdata1_q <= 16'h0000;
        end else begin
            if (m0_ack && !bus_we) rdata0_q <= mmio_rdata;
            if (m1_ack && !bus_we) rdata1_q <= mmio_rdata;
        end
    end

    // Bus strobes come straight from state so reset kills them asynchronously
    assign mmio_en = (state == ISSUE);
    assign mmio_we = mmio_en & bus_we;

    // Response: slave data is already registered, so it is forwarded during ack
    assign resp     = (state == RESP);
    assign m0_ack   = resp & ~owner;
    assign m1_ack   = resp & owner;
    assign m0_err   = m0_ack & ~bus_we & ~mmio_serviced;
    assign m1_err   = m1_ack & ~bus_we & ~mmio_serviced;
    assign m0_rdata = (m0_ack && !bus_we) ? mmio_rdata : rdata0_q;
    assign m1_rdata = (m1_ack && !bus_we) ? mmio_rdata : rdata1_q;

endmodule

// File: tb/tb_mmio_arbiter.sv
// tb_mmio_arbiter: directed test-plan scenarios plus random two-master traffic,
// checked against a transaction-level model (LED register, read map, arbitration rule).
`timescale 1ns/1ps
module tb_mmio_arbiter;

    localparam logic [15:0] UART_RX = 16'h0041;
    localparam logic [15:0] UART_ST = 16'h0003;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        bsel;
        logic        ben;
        int          gap;
    } xact_t;

    typedef struct {
        int   m;
        int   lat;
        int   cyc;
        logic err;
    } ack_rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0]       req, we, bsel, ben;
    logic [1:0][15:0] addr, wdata;
    wire  [1:0]       ack, err;
    wire  [1:0][15:0] rdata;
    wire              mmio_en, mmio_we, mmio_bsel, mmio_ben;
    wire  [15:0]      mmio_addr, mmio_wdata;
    logic [15:0]      s_rdata = 16'h0000;
    logic             s_serv  = 1'b0;
    logic [7:0]       led     = 8'h00;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done[2] = '{0, 0};
    int want[2] = '{0, 0};
    int raise_cyc[2] = '{0, 0};
    xact_t    mq[2][$];
    ack_rec_t ack_log[$];

    mmio_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
        .m0_bsel(bsel[0]), .m0_ben(ben[0]),
        .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
        .m1_bsel(bsel[1]), .m1_ben(ben[1]),
        .m0_ack(ack[0]), .m0_rdata(rdata[0]), .m0_err(err[0]),
        .m1_ack(ack[1]), .m1_rdata(rdata[1]), .m1_err(err[1]),
        .mmio_en(mmio_en), .mmio_we(mmio_we), .mmio_addr(mmio_addr),
        .mmio_wdata(mmio_wdata), .mmio_bsel(mmio_bsel), .mmio_ben(mmio_ben),
        .mmio_rdata(s_rdata), .mmio_serviced(s_serv)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in MMIO slave: LED register plus UART data/status, registered reads
    always @(posedge clk) begin
        if (mmio_en) begin
            if (mmio_we) begin
                if (mmio_addr == 16'hff00) led <= mmio_wdata[7:0];
            end else begin
                case (mmio_addr)
                    16'hff00: begin s_rdata <= {8'h00, led}; s_serv <= 1'b1; end
                    16'hff02: begin s_rdata <= UART_RX;      s_serv <= 1'b1; end
                    16'hff03: begin s_rdata <= UART_ST;      s_serv <= 1'b1; end
                    default:  begin s_rdata <= 16'h0000;     s_serv <= 1'b0; end
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected {serviced, data} of a read, from the MMIO address map
    function automatic logic [16:0] ref_read(input logic [15:0] a, input logic [7:0] l);
        if (a == 16'hff00) return {1'b1, 8'h00, l};
        if (a == 16'hff02) return {1'b1, UART_RX};
        if (a == 16'hff03) return {1'b1, UART_ST};
        return 17'h0;
    endfunction

    task automatic push(input int m, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input int gap);
        xact_t x;
        x.we = w; x.addr = a; x.wdata = d; x.gap = gap;
        x.bsel = 1'($urandom_range(0, 1));
        x.ben  = 1'($urandom_range(0, 1));
        mq[m].push_back(x);
        want[m]++;
    endtask

    task automatic wait_all(input int bound);
        int n = 0;
        while ((done[0] != want[0] || done[1] != want[1]) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("wait_all", 64'(n < bound), 64'(1));
        @(negedge clk);
    endtask

    // Master drivers: hold req and fields until ack, optional idle gap between requests
    initial begin : drv
        xact_t cur[2];
        bit    active[2];
        bit    have[2];
        int    gapc[2];
        int    waitc[2];
        logic [1:0] a;
        req = '0; we = '0; bsel = '0; ben = '0; addr = '0; wdata = '0;
        for (int g = 0; g < 2; g++) begin
            active[g] = 0; have[g] = 0; gapc[g] = 0; waitc[g] = 0;
        end
        forever begin
            @(negedge clk);
            a = ack;
            @(posedge clk);
            #1;
            for (int g = 0; g < 2; g++) begin
                if (!rst) begin
                    active[g] = 0;
                    req[g]    = 1'b0;
                end else begin
                    if (active[g] && a[g]) begin
                        active[g] = 0;
                        req[g]    = 1'b0;
                        done[g]++;
                    end
                    if (active[g]) begin
                        waitc[g]++;
                        if (waitc[g] > 400) begin
                            chk("ack_wait", 64'(waitc[g]), 64'(400));
                            active[g] = 0;
                            req[g]    = 1'b0;
                            done[g]++;
                        end
                    end
                    if (!active[g] && !have[g] && mq[g].size() != 0) begin
                        cur[g]  = mq[g].pop_front();
                        have[g] = 1;
                        gapc[g] = cur[g].gap;
                    end
                    if (have[g]) begin
                        if (gapc[g] == 0) begin
                            req[g] = 1'b1; we[g] = cur[g].we; addr[g] = cur[g].addr;
                            wdata[g] = cur[g].wdata; bsel[g] = cur[g].bsel; ben[g] = cur[g].ben;
                            have[g] = 0; active[g] = 1; waitc[g] = 0;
                            raise_cyc[g] = cyc;
                        end else begin
                            gapc[g]--;
                        end
                    end
                end
            end
        end
    end

    // Monitor and reference model, sampled on the falling edge
    initial begin : mon
        logic        prev_en;
        logic [1:0]  cand_prev, prev_ack, iss_cand;
        logic        last_w;
        logic [34:0] iss_bus;
        logic [7:0]  led_m;
        logic [15:0] exp_rd[2];
        prev_en = 0; cand_prev = 0; prev_ack = 0; iss_cand = 0; last_w = 1;
        iss_bus = '0; led_m = 8'h00; exp_rd[0] = 0; exp_rd[1] = 0;
        forever begin
            logic [1:0]  cand;
            logic [16:0] r;
            logic        need_issue, exempt, e_err, exp_w;
            int          w;
            ack_rec_t    rec;
            @(negedge clk);
            if (!rst) begin
                chk("rst_resp", 64'({ack, err, rdata}), 64'(0));
                chk("rst_bus", 64'({mmio_en, mmio_we, mmio_addr, mmio_wdata, mmio_bsel, mmio_ben}), 64'(0));
                prev_en = 0; cand_prev = 0; prev_ack = 0; last_w = 1;
                exp_rd[0] = 0; exp_rd[1] = 0;
            end else begin
                cand = req & ~ack;
                chk("en_b2b", 64'(prev_en & mmio_en), 64'(0));
                chk("we_wo_en", 64'(mmio_we & ~mmio_en), 64'(0));
`ifdef MMIO_ARB_FIXED_PRIO_EN
                exempt = prev_ack[0] && (cand_prev == 2'b10);
`else
                exempt = 1'b0;
`endif
                need_issue = !prev_en && (cand_prev != 2'b00) && !exempt;
                chk("issue_rule", 64'(mmio_en), 64'(need_issue));
                if (mmio_en) begin
                    iss_cand = cand_prev;
                    iss_bus  = {mmio_we, mmio_addr, mmio_wdata, mmio_bsel, mmio_ben};
                end
                if (ack != 2'b00) begin
                    chk("ack_onehot", 64'($countones(ack)), 64'(1));
                    w = ack[1] ? 1 : 0;
                    chk("ack_after_issue", 64'(prev_en), 64'(1));
                    chk("bus_fields", 64'(iss_bus), 64'({we[w], addr[w], wdata[w], bsel[w], ben[w]}));
`ifdef MMIO_ARB_FIXED_PRIO_EN
                    exp_w = 1'b0;
`else
                    exp_w = ~last_w;
`endif
                    if (iss_cand == 2'b11) chk("arb_contend", 64'(w), 64'(exp_w));
                    else                   chk("arb_single", 64'(iss_cand[w]), 64'(1));
                    last_w = w[0];
                    if (we[w]) begin
                        if (addr[w] == 16'hff00) led_m = wdata[w][7:0];
                        e_err = 1'b0;
                    end else begin
                        r = ref_read(addr[w], led_m);
                        exp_rd[w] = r[15:0];
                        e_err = ~r[16];
                    end
                    chk("ack_rdata", 64'(rdata[w]), 64'(exp_rd[w]));
                    chk("ack_err", 64'(err[w]), 64'(e_err));
                    rec.m = w; rec.lat = cyc - raise_cyc[w]; rec.cyc = cyc; rec.err = err[w];
                    ack_log.push_back(rec);
                end
                for (int g = 0; g < 2; g++)
                    if (!ack[g]) chk("idle_out", 64'({err[g], rdata[g]}), 64'({1'b0, exp_rd[g]}));
                prev_en = mmio_en; cand_prev = cand; prev_ack = ack;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin : main
        logic [15:0] a;
        logic [7:0]  led_before;
        int          n;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;

        // Idle after reset: no bus activity
        repeat (10) begin
            @(negedge clk);
            chk("idle_en", 64'(mmio_en), 64'(0));
        end

        // m0 writes LED
        ack_log.delete();
        push(0, 1'b1, 16'hff00, 16'h00a5, 0);
        wait_all(50);
        chk("wr_nacks", 64'(ack_log.size()), 64'(1));
        if (ack_log.size() >= 1) begin
            chk("wr_master", 64'(ack_log[0].m), 64'(0));
            chk("wr_lat", 64'(ack_log[0].lat), 64'(2));
            chk("wr_err", 64'(ack_log[0].err), 64'(0));
        end
        chk("wr_led", 64'(led), 64'(8'ha5));

        // m1 reads LED back
        ack_log.delete();
        push(1, 1'b0, 16'hff00, 16'h0000, 0);
        wait_all(50);
        chk("rd_nacks", 64'(ack_log.size()), 64'(1));
        if (ack_log.size() >= 1) begin
            chk("rd_master", 64'(ack_log[0].m), 64'(1));
            chk("rd_lat", 64'(ack_log[0].lat), 64'(2));
            chk("rd_err", 64'(ack_log[0].err), 64'(0));
        end
        chk("rd_m1_data", 64'(rdata[1]), 64'(16'h00a5));

        // m0 reads an unmapped address
        ack_log.delete();
        push(0, 1'b0, 16'h1234, 16'h0000, 0);
        wait_all(50);
        if (ack_log.size() >= 1) begin
            chk("unm_lat", 64'(ack_log[0].lat), 64'(2));
            chk("unm_err", 64'(ack_log[0].err), 64'(1));
        end
        chk("unm_data", 64'(rdata[0]), 64'(0));

        // Contention straight after reset
        @(negedge clk); #2 rst = 1'b0;
        @(negedge clk); #2 rst = 1'b1;
        ack_log.delete();
`ifdef MMIO_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) push(0, 1'b0, 16'hff03, 16'h0000, 0);
        push(1, 1'b0, 16'hff02, 16'h0000, 0);
        wait_all(100);
        chk("ctn_nacks", 64'(ack_log.size()), 64'(5));
        if (ack_log.size() == 5) begin
            for (int i = 0; i < 4; i++) chk("ctn_master", 64'(ack_log[i].m), 64'(0));
            for (int i = 1; i < 4; i++) chk("ctn_gap", 64'(ack_log[i].cyc - ack_log[i-1].cyc), 64'(3));
            chk("ctn_last", 64'(ack_log[4].m), 64'(1));
        end
`else
        for (int i = 0; i < 2; i++) begin
            push(0, 1'b0, 16'hff03, 16'h0000, 0);
            push(1, 1'b0, 16'hff02, 16'h0000, 0);
        end
        wait_all(100);
        chk("ctn_nacks", 64'(ack_log.size()), 64'(4));
        if (ack_log.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("ctn_master", 64'(ack_log[i].m), 64'(i % 2));
            for (int i = 1; i < 4; i++) chk("ctn_gap", 64'(ack_log[i].cyc - ack_log[i-1].cyc), 64'(2));
        end
`endif

        // Reset during ISSUE of an m1 write
        ack_log.delete();
        led_before = led;
        push(1, 1'b1, 16'hff00, 16'h005a, 0);
        n = 0;
        @(negedge clk);
        while (!mmio_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_issue", 64'(mmio_en), 64'(1));
        #2 rst = 1'b0;
        #1;
        chk("abort_en_drop", 64'(mmio_en), 64'(0));
        chk("abort_addr_clr", 64'(mmio_addr), 64'(0));
        repeat (3) @(negedge clk);
        chk("abort_noack", 64'(ack_log.size()), 64'(0));
        chk("abort_led", 64'(led), 64'(led_before));
        want[1]--;
        #2 rst = 1'b1;
        push(1, 1'b1, 16'hff00, 16'h005a, 0);
        wait_all(50);
        chk("reissue_nacks", 64'(ack_log.size()), 64'(1));
        if (ack_log.size() >= 1) chk("reissue_lat", 64'(ack_log[0].lat), 64'(2));
        chk("reissue_led", 64'(led), 64'(8'h5a));

        // Random traffic from both masters
        for (int i = 0; i < 150; i++) begin
            for (int m = 0; m < 2; m++) begin
                case ($urandom_range(0, 4))
                    0, 4:    a = 16'hff00;
                    1:       a = 16'hff02;
                    2:       a = 16'hff03;
                    default: a = 16'($urandom);
                endcase
                push(m, 1'($urandom_range(0, 1)), a, 16'($urandom), $urandom_range(0, 3));
            end
        end
        wait_all(20000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_arbiter.md
# mmio_arbiter

Two-master arbiter and sequencer for the memory-mapped I/O block (LEDs at 0xff00, UART data at 0xff02, UART status at 0xff03). Sits between the CPU data port (master 0) and a secondary master such as a DMA or debug engine (master 1) on one side, and the single MMIO slave port on the other. Grants one master at a time, drives exactly one single-cycle MMIO access per grant, captures the slave's registered read data, and returns a one-cycle acknowledge with data and error status.

## Interface
- No parameters; address and data widths are fixed at 16 bits.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- m0_req, m1_req  in  1  master request; held high until that master's ack
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  16  word address as presented to MMIO
- m0_wdata, m1_wdata  in  16  write data
- m0_bsel, m1_bsel  in  1  byte select, passed through
- m0_ben, m1_ben  in  1  byte enable, passed through
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_rdata, m1_rdata  out  16  read data, valid while ack is high, held until next ack
- m0_err, m1_err  out  1  high with ack when a read was not serviced
- mmio_en  out  1  slave enable, high only in ISSUE
- mmio_we  out  1  slave write_enable, high only in ISSUE of a write
- mmio_addr, mmio_wdata  out  16  latched request fields
- mmio_bsel, mmio_ben  out  1  latched byte select / byte enable
- mmio_rdata  in  16  slave data_out (registered in slave)
- mmio_serviced  in  1  slave serviced_read (registered in slave)

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state IDLE.
- IDLE: if any eligible req, pick winner, latch its we/addr/wdata/bsel/ben into bus registers, record owner, go ISSUE. Otherwise stay.
- ISSUE: mmio_en=1, mmio_we=latched we; bus fields stable. Always go RESP.
- RESP: owner's ack=1; for reads, owner's rdata ← mmio_rdata, err ← ~mmio_serviced; for writes, rdata unchanged, err=0. The other master's req, if high, wins immediately (latch, go ISSUE); else go IDLE.
- Owner's req is ignored during RESP (stale, master drops it after seeing ack); same-master back-to-back therefore costs one IDLE cycle.
- Arbitration (default round-robin): one-bit last_owner; on contention grant the master that is not last_owner; with a single requester grant it. last_owner resets to 1, so master 0 wins the first contention.
- Non-owner outputs: ack=0, err=0, rdata held.
- Reset: all outputs 0 (acks, errs, rdata, mmio_* bus, mmio_en, mmio_we), state IDLE, last_owner=1. Asserted mid-transaction, mmio_en drops asynchronously; transaction is abandoned with no ack; masters reissue after reset.

## Timing
- Cycle t: req sampled high in IDLE. t+1: ISSUE, mmio_en=1 (slave writes / registers read data at end of t+1). t+2: RESP, ack with data. Latency 2 cycles request-to-ack.
- Contended back-to-back: RESP of one master overlaps arbitration of the other; sustained throughput one transaction per 2 cycles.
- Single master back-to-back: 3 cycles per transaction.
- mmio_en never high two consecutive cycles.
- Requests with req low before ack are undefined; masters must not change fields while req is high and not yet granted-and-latched.

## Configuration
- MMIO_ARB_FIXED_PRIO_EN defined: fixed priority, master 0 always wins contention; last_owner not implemented; master 1 may starve.
- Undefined (default): round-robin as in Operation.

## Test plan
- Reset with all reqs low -> all outputs 0, mmio_en stays 0 for 10 cycles.
- m0 write 0xff00, wdata 0x00a5 -> mmio_en/mmio_we high exactly one cycle at t+1 with addr 0xff00, m0_ack at t+2, m0_err=0, LED output becomes 0xa5.
- m1 read 0xff00 after above -> m1_ack at t+2, m1_rdata=0x00a5, m1_err=0; m0_ack stays 0.
- m0 read 0x1234 -> m0_ack at t+2, m0_rdata=0x0000, m0_err=1.
- m0 and m1 both request continuously for 4 transactions -> grants alternate m0,m1,m0,m1, acks every 2 cycles; with MMIO_ARB_FIXED_PRIO_EN all 4 go to m0 (3-cycle spacing).
- rst asserted during ISSUE of an m1 write -> mmio_en drops immediately, no ack, write not performed; after release, m1 reissue completes normally.
